// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Purpose  : Shared constants for the iterative multiply/divide sequencer:
//             operation codes as presented by Execute, FSM state encodings
//             and small decode helpers.
//  Contents : OP_MULT/OP_MULTU/OP_DIV/OP_DIVU, S_IDLE/S_CALC/S_FIX,
//             op_is_div(), op_is_signed()
//  Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

  // Operation codes (OpE)
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Sequencer states (2-bit encoding; 2'b11 is unused and recovers to IDLE)
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CALC = 2'b01;
  localparam logic [1:0] S_FIX  = 2'b10;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_core.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iter_core
//  Purpose  : One combinational iteration of the multiply/divide loop on
//             unsigned magnitudes.
//             mode=0 (multiply): acc = {partial_hi, multiplier_lo}; if the
//               multiplier LSB is set add the multiplicand to the high half,
//               then shift the whole 2W+1 value right by one.
//             mode=1 (divide): acc = {remainder, dividend_lo}; shift left by
//               one, trial-subtract the divisor from the remainder and keep
//               the difference (quotient bit 1) unless it borrowed.
//  Ports    : acc      in  2*DATA_WIDTH  current accumulator
//             operand  in  DATA_WIDTH    multiplicand / divisor magnitude
//             mode     in  1             0 multiply, 1 divide
//             acc_next out 2*DATA_WIDTH  accumulator after this step
//  Revision : 1.0  initial release
// ============================================================================
module mdu_iter_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   operand,
  input  logic                    mode,
  output logic [2*DATA_WIDTH-1:0] acc_next
);

  logic [DATA_WIDTH-1:0] w_hi;
  logic [DATA_WIDTH-1:0] w_lo;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH:0]   w_diff;

  assign w_hi = acc[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_lo = acc[DATA_WIDTH-1:0];

  // Multiply: carry out of the add becomes the new MSB after the shift.
  assign w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, operand} : '0);

  // Divide: the remainder is always below the divisor (or the divisor is zero
  // and the remainder holds at most W-1 dividend bits), so the shifted value
  // minus the divisor lands below 2^W when it fits and wraps to >= 2^W when it
  // does not. Bit W of the difference is therefore the borrow.
  assign w_shift = {w_hi, w_lo[DATA_WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, operand};

  always_comb begin
    acc_next = acc;
    if (!mode) begin
      acc_next = {w_sum, w_lo[DATA_WIDTH-1:1]};
    end else if (w_diff[DATA_WIDTH]) begin
      acc_next = {w_shift[DATA_WIDTH-1:0], w_lo[DATA_WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {w_diff[DATA_WIDTH-1:0], w_lo[DATA_WIDTH-2:0], 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Multi-cycle controller for MULT/MULTU/DIV/DIVU and the HI/LO
//             registers. Latches operand magnitudes and result signs at
//             start, runs DATA_WIDTH iterations, then applies signs and
//             writes HI/LO in a final FIX cycle.
//  Ports    : CLK     in   1    clock, rising edge
//             RST     in   1    asynchronous active-low reset
//             StartE  in   1    MULT*/DIV* present in Execute
//             OpE     in   2    00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//             SrcAE   in   W    rs operand (multiplicand / dividend)
//             SrcBE   in   W    rt operand (multiplier / divisor)
//             MtHiE   in   1    MTHI in Execute (HI <= SrcAE)
//             MtLoE   in   1    MTLO in Execute (LO <= SrcAE)
//             MdUseD  in   1    Decode instruction uses the unit
//             HI      out  W    HI register
//             LO      out  W    LO register
//             BusyMD  out  1    unit in CALC or FIX
//             StallMD out  1    BusyMD & MdUseD
//             DoneMD  out  1    high in the cycle HI/LO take the result
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_sequencer
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  StartE,
  input  logic [1:0]            OpE,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic                  MtHiE,
  input  logic                  MtLoE,
  input  logic                  MdUseD,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO,
  output logic                  BusyMD,
  output logic                  StallMD,
  output logic                  DoneMD
);

  localparam logic [CNT_WIDTH-1:0] c_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [1:0]              r_state;
  logic [1:0]              w_next;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [2*DATA_WIDTH-1:0] r_acc;
  logic [2*DATA_WIDTH-1:0] w_acc_next;
  logic [DATA_WIDTH-1:0]   r_opnd;
  logic                    r_div;
  logic                    r_neg_q;   // product / quotient negative
  logic                    r_neg_r;   // remainder negative (dividend sign)
  logic                    r_dz;      // divide by zero
  logic [DATA_WIDTH-1:0]   r_hi;
  logic [DATA_WIDTH-1:0]   r_lo;
  logic                    w_busy;
  logic                    w_done;
  logic                    w_accept;

  // --------------------------------------------------------------------------
  // Operand capture decode
  // --------------------------------------------------------------------------
  logic                  w_op_div;
  logic                  w_op_signed;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_WIDTH-1:0] w_abs_a;
  logic [DATA_WIDTH-1:0] w_abs_b;

  assign w_op_div    = op_is_div(OpE);
  assign w_op_signed = op_is_signed(OpE);
  assign w_a_neg     = w_op_signed & SrcAE[DATA_WIDTH-1];
  assign w_b_neg     = w_op_signed & SrcBE[DATA_WIDTH-1];
  // -0x80000000 wraps back to 0x80000000, which is the correct unsigned magnitude.
  assign w_abs_a     = w_a_neg ? (~SrcAE + 1'b1) : SrcAE;
  assign w_abs_b     = w_b_neg ? (~SrcBE + 1'b1) : SrcBE;
  assign w_accept    = (r_state == S_IDLE) & StartE;

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (StartE) w_next = S_CALC;
      S_CALC:  if (r_cnt == c_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_CALC:  w_busy = 1'b1;
      S_FIX: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Iteration counter
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == S_CALC) begin
      r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  mdu_iter_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_iter (
    .acc      (r_acc),
    .operand  (r_opnd),
    .mode     (r_div),
    .acc_next (w_acc_next)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_acc   <= '0;
      r_opnd  <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_div   <= w_op_div;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dz    <= w_op_div & (SrcBE == '0);
      if (w_op_div) begin
        r_acc  <= {{DATA_WIDTH{1'b0}}, w_abs_a};  // remainder 0, dividend low
        r_opnd <= w_abs_b;
      end else begin
        r_acc  <= {{DATA_WIDTH{1'b0}}, w_abs_b};  // partial 0, multiplier low
        r_opnd <= w_abs_a;
      end
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_next;
    end
  end

  // --------------------------------------------------------------------------
  // Sign fix-up
  // --------------------------------------------------------------------------
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   w_quo;
  logic [DATA_WIDTH-1:0]   w_rem;
  logic [DATA_WIDTH-1:0]   w_res_hi;
  logic [DATA_WIDTH-1:0]   w_res_lo;

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  // Divide by zero: the magnitude loop leaves |dividend| as remainder, so the
  // dividend-sign fix-up restores the raw dividend in HI; only LO is forced.
  assign w_quo  = r_dz    ? {DATA_WIDTH{1'b1}} :
                  r_neg_q ? (~r_acc[DATA_WIDTH-1:0] + 1'b1) : r_acc[DATA_WIDTH-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[2*DATA_WIDTH-1:DATA_WIDTH] + 1'b1)
                          : r_acc[2*DATA_WIDTH-1:DATA_WIDTH];

  assign w_res_hi = r_div ? w_rem : w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_res_lo = r_div ? w_quo : w_prod[DATA_WIDTH-1:0];

  // --------------------------------------------------------------------------
  // HI / LO
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if ((r_state == S_IDLE) && !StartE) begin
      // A start in the same cycle takes priority over MTHI/MTLO.
      if (MtHiE) r_hi <= SrcAE;
      if (MtLoE) r_lo <= SrcAE;
    end
  end

  assign HI      = r_hi;
  assign LO      = r_lo;
  assign BusyMD  = w_busy;
  assign DoneMD  = w_done;
  assign StallMD = w_busy & MdUseD;

  // A start reaching Execute while busy is dropped; it is only legitimate if
  // the hazard unit was stalling at the same time.
  a_no_unstalled_start : assert property (
    @(posedge CLK) disable iff (!RST) (StartE && w_busy) |-> StallMD
  ) else $error("muldiv_sequencer: StartE while unit busy without stall");

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_sequencer
//  Purpose  : Self-checking bench for muldiv_sequencer. Directed cases plus
//             random operations compared against an arithmetic reference
//             model (64-bit products, native signed/unsigned divide).
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        StartE = 1'b0;
  logic [1:0]  OpE = 2'b00;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        MtHiE = 1'b0;
  logic        MtLoE = 1'b0;
  logic        MdUseD = 1'b0;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        BusyMD;
  logic        StallMD;
  logic        DoneMD;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .StartE  (StartE),
    .OpE     (OpE),
    .SrcAE   (SrcAE),
    .SrcBE   (SrcBE),
    .MtHiE   (MtHiE),
    .MtLoE   (MtLoE),
    .MdUseD  (MdUseD),
    .HI      (HI),
    .LO      (LO),
    .BusyMD  (BusyMD),
    .StallMD (StallMD),
    .DoneMD  (DoneMD)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: architectural result of one operation.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint          p;
    longint unsigned up;
    int              sa;
    int              sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin p = longint'(sa) * longint'(sb); {h, l} = p; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; {h, l} = up; end
      2'b10: begin
        if (b == 0) begin l = 32'hFFFFFFFF; h = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin l = 32'h80000000; h = 32'h0; end
        else begin l = sa / sb; h = sa % sb; end
      end
      default: begin
        if (b == 0) begin l = 32'hFFFFFFFF; h = a; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  // Issue one op, then follow it cycle by cycle to completion.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mduse, input logic poke);
    logic [31:0] nh;
    logic [31:0] nl;
    model(op, a, b, nh, nl);
    @(negedge CLK);
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b; MdUseD = mduse;
    @(posedge CLK); #1;
    StartE = 1'b0; SrcAE = $urandom; SrcBE = $urandom;   // operands must already be latched
    for (int c = 1; c <= 33; c++) begin
      if (poke && c == 10) begin StartE = 1'b1; OpE = 2'($urandom); end
      if (poke && c == 11) StartE = 1'b0;
      @(posedge CLK); #1;
      if (c < 33) begin
        chk("busy", 32'(BusyMD), 32'd1);
        chk("done", 32'(DoneMD), 32'(c == 32));
        chk("hi_hold", HI, exp_hi);
        chk("lo_hold", LO, exp_lo);
        if (mduse) chk("stall_busy", 32'(StallMD), 32'd1);
      end else begin
        chk("busy_end", 32'(BusyMD), 32'd0);
        chk("done_end", 32'(DoneMD), 32'd0);
        chk("stall_end", 32'(StallMD), 32'd0);
        chk("hi_res", HI, nh);
        chk("lo_res", LO, nl);
      end
    end
    MdUseD = 1'b0;
    exp_hi = nh;
    exp_lo = nl;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset state, with Decode claiming the unit
    MdUseD = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy", 32'(BusyMD), 32'd0);
    chk("rst_done", 32'(DoneMD), 32'd0);
    chk("rst_stall", 32'(StallMD), 32'd0);
    MdUseD = 1'b0;
    @(negedge CLK); RST = 1'b1;

    // MULTU max*max
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("t1_hi", HI, 32'hFFFFFFFE);
    chk("t1_lo", LO, 32'h00000001);
    // MULT -3*7
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
    chk("t2_hi", HI, 32'hFFFFFFFF);
    chk("t2_lo", LO, 32'hFFFFFFEB);
    // DIV -7/2, DIVU 7/0
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    chk("t3a_hi", HI, 32'hFFFFFFFF);
    chk("t3a_lo", LO, 32'hFFFFFFFD);
    run_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0);
    chk("t3b_hi", HI, 32'd7);
    chk("t3b_lo", LO, 32'hFFFFFFFF);
    // Signed overflow divide
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("t4_hi", HI, 32'h0);
    chk("t4_lo", LO, 32'h80000000);
    // Signed divide by zero with negative dividend
    run_op(2'b10, 32'hFFFF0000, 32'd0, 1'b0, 1'b0);
    chk("dz_hi", HI, 32'hFFFF0000);
    chk("dz_lo", LO, 32'hFFFFFFFF);
    // Stall while busy, plus a stray start that must be ignored
    run_op(2'b00, 32'd123456, 32'hFFFFFF00, 1'b1, 1'b1);

    // MTHI / MTLO in idle
    @(negedge CLK); MtHiE = 1'b1; SrcAE = 32'hCAFEF00D;
    @(posedge CLK); #1; MtHiE = 1'b0;
    chk("mthi_hi", HI, 32'hCAFEF00D);
    chk("mthi_lo", LO, exp_lo);
    chk("mthi_done", 32'(DoneMD), 32'd0);
    exp_hi = 32'hCAFEF00D;

    // Random operations
    for (int i = 0; i < 14; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 5));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if (i % 4 == 3) ra = 32'h80000000;
      run_op(rop, ra, rb, 1'(i % 2), 1'b0);
    end

    // Reset mid-operation (iteration 15), then MTLO
    @(negedge CLK);
    StartE = 1'b1; OpE = 2'b01; SrcAE = 32'hDEADBEEF; SrcBE = 32'h12345678;
    @(posedge CLK); #1; StartE = 1'b0;
    repeat (15) @(posedge CLK);
    #2; RST = 1'b0; MdUseD = 1'b1;
    #1;
    chk("mid_rst_hi", HI, 32'h0);
    chk("mid_rst_lo", LO, 32'h0);
    chk("mid_rst_busy", 32'(BusyMD), 32'd0);
    chk("mid_rst_stall", 32'(StallMD), 32'd0);
    @(negedge CLK); RST = 1'b1; MdUseD = 1'b0;
    @(negedge CLK); MtLoE = 1'b1; SrcAE = 32'h00001234;
    @(posedge CLK); #1; MtLoE = 1'b0;
    chk("mtlo_lo", LO, 32'h00001234);
    chk("mtlo_hi", HI, 32'h0);
    chk("mtlo_busy", 32'(BusyMD), 32'd0);
    repeat (40) @(posedge CLK);
    #1;
    chk("no_resume_lo", LO, 32'h00001234);
    chk("no_resume_busy", 32'(BusyMD), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
